// File: rtl/parser_pkg.sv
// Shared types and helpers for the packet parser stages.
// Optional statistics in phv_assembler are enabled with PHV_ASM_STATS_EN.
package parser_pkg;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_PHV_WIDTH  = 1024;
    // Mask helper is built at a fixed width wider than any supported beat.
    localparam int MASK_MAX_W     = 2048;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } asm_state_e;

    // Bytes [empty, nbytes) counted from the LSB side are kept; the rest read zero.
    function automatic logic [MASK_MAX_W-1:0] empty_mask(input int unsigned nbytes,
                                                          input int unsigned empty);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < MASK_MAX_W/8; b++)
            if (b < nbytes && b >= empty)
                m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

endpackage

// File: rtl/phv_beat_mask.sv
// Zeroes the trailing (LSB-side) empty bytes of a stream beat when it is the last one.
module phv_beat_mask
    import parser_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8)
) (
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   last_i,
    input  logic [EMPTY_WIDTH-1:0] empty_i,
    output logic [DATA_WIDTH-1:0]  data_o
);

    logic [MASK_MAX_W-1:0] mask_full;
    logic                  unused_mask_hi;

    assign mask_full      = empty_mask(DATA_WIDTH/8, 32'(empty_i));
    assign unused_mask_hi = ^mask_full[MASK_MAX_W-1:DATA_WIDTH];
    assign data_o         = last_i ? (data_i & mask_full[DATA_WIDTH-1:0]) : data_i;

endmodule

// File: rtl/phv_assembler.sv
// Assembles the leading PHV_WIDTH bits of a beat-serial packet into one PHV word.
// Define PHV_ASM_STATS_EN to build the emitted/truncated packet counters.
module phv_assembler
    import parser_pkg::*;
#(
    parameter int PHV_WIDTH   = DEF_PHV_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BEATS       = PHV_WIDTH/DATA_WIDTH,
    parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8),
    parameter int LEN_WIDTH   = $clog2(PHV_WIDTH/8)+1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_pkt_valid,
    input  logic [DATA_WIDTH-1:0]  i_pkt_data,
    input  logic                   i_pkt_last,
    input  logic [EMPTY_WIDTH-1:0] i_pkt_empty,
    output logic                   o_pkt_ready,
    output logic                   o_phv_out_valid,
    output logic [PHV_WIDTH-1:0]   o_phv_out,
    output logic [LEN_WIDTH-1:0]   o_phv_len,
    output logic                   o_phv_trunc,
    input  logic                   i_phv_ready,
    output logic [31:0]            o_pkt_cnt,
    output logic [31:0]            o_trunc_cnt
);

    localparam int BIDX_W = $clog2(BEATS)+1;
    localparam int LW1    = LEN_WIDTH+1;
    localparam int DWB    = DATA_WIDTH/8;

    asm_state_e            state_q;
    logic [BIDX_W-1:0]     beat_idx_q;
    logic                  pend_q;
    logic [PHV_WIDTH-1:0]  phv_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  trunc_q;
    logic                  valid_q;

    logic [DATA_WIDTH-1:0] beat_masked;
    logic [LW1-1:0]        len_calc;
    logic                  unused_len_msb;
    logic                  accept;
    logic                  at_end;

    phv_beat_mask #(
        .DATA_WIDTH  (DATA_WIDTH),
        .EMPTY_WIDTH (EMPTY_WIDTH)
    ) u_mask (
        .data_i  (i_pkt_data),
        .last_i  (i_pkt_last),
        .empty_i (i_pkt_empty),
        .data_o  (beat_masked)
    );

    // Ready depends on state only, never on the downstream ready.
    assign o_pkt_ready    = (state_q != HOLD);
    assign accept         = i_pkt_valid & o_pkt_ready;
    assign at_end         = (beat_idx_q == BIDX_W'(BEATS-1));
    assign len_calc       = LW1'(beat_idx_q) * LW1'(DWB) + LW1'(DWB) - LW1'(i_pkt_empty);
    assign unused_len_msb = len_calc[LEN_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= FILL;
            beat_idx_q <= '0;
            pend_q     <= 1'b0;
            phv_q      <= '0;
            len_q      <= '0;
            trunc_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < BEATS; k++)
                            if (beat_idx_q == BIDX_W'(k))
                                phv_q[PHV_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] <= beat_masked;
                        beat_idx_q <= beat_idx_q + 1'b1;
                        if (i_pkt_last || at_end) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                            pend_q  <= ~i_pkt_last;
                            trunc_q <= ~i_pkt_last;
                            len_q   <= i_pkt_last ? len_calc[LEN_WIDTH-1:0]
                                                  : LEN_WIDTH'(PHV_WIDTH/8);
                        end
                    end
                end
                HOLD: begin
                    if (i_phv_ready) begin
                        valid_q    <= 1'b0;
                        beat_idx_q <= '0;
                        if (pend_q) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= FILL;
                            phv_q   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && i_pkt_last) begin
                        state_q <= FILL;
                        pend_q  <= 1'b0;
                        phv_q   <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign o_phv_out_valid = valid_q;
    assign o_phv_out       = phv_q;
    assign o_phv_len       = len_q;
    assign o_phv_trunc     = trunc_q;

`ifdef PHV_ASM_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] trunc_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else if (valid_q && i_phv_ready) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (trunc_q)
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
        end
    end

    assign o_pkt_cnt   = pkt_cnt_q;
    assign o_trunc_cnt = trunc_cnt_q;
`else
    assign o_pkt_cnt   = 32'd0;
    assign o_trunc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_phv_assembler.sv
// Directed bench for phv_assembler with a packet-level reference model and per-cycle compare.
module tb_phv_assembler;

    localparam int PW    = 1024;
    localparam int DW    = 256;
    localparam int BEATS = PW/DW;
    localparam int DWB   = DW/8;
    localparam int EW    = $clog2(DWB);
    localparam int LW    = $clog2(PW/8)+1;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic [DW-1:0] data;
    logic          last;
    logic [EW-1:0] empty;
    logic          pkt_ready;
    logic          phv_valid;
    logic [PW-1:0] phv_out;
    logic [LW-1:0] phv_len;
    logic          phv_trunc;
    logic          phv_rdy;
    logic [31:0]   pkt_cnt;
    logic [31:0]   trunc_cnt;

    always #5 clk = ~clk;

    phv_assembler dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pkt_valid     (vld),
        .i_pkt_data      (data),
        .i_pkt_last      (last),
        .i_pkt_empty     (empty),
        .o_pkt_ready     (pkt_ready),
        .o_phv_out_valid (phv_valid),
        .o_phv_out       (phv_out),
        .o_phv_len       (phv_len),
        .o_phv_trunc     (phv_trunc),
        .i_phv_ready     (phv_rdy),
        .o_pkt_cnt       (pkt_cnt),
        .o_trunc_cnt     (trunc_cnt)
    );

    typedef struct {
        logic [PW-1:0] phv;
        int            len;
        bit            trunc;
    } exp_t;

    exp_t          expq[$];
    exp_t          e_item;
    logic [PW-1:0] m_acc;
    int            m_n;
    bit            m_drain;
    int            m_pkt;
    int            m_trunc;
    bit            armed = 1'b0;
    bit            hold;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_phv(input string n, input logic [PW-1:0] a, input logic [PW-1:0] e);
        int fb;
        checks++;
        if (a !== e) begin
            fb = 0;
            for (int i = PW-1; i >= 0; i--)
                if (a[i] !== e[i]) begin fb = i; break; end
            failures++;
            $display("FAIL %s: first diff bit %0d, word got %h expected %h at %0t",
                     n, fb, a[(fb/64)*64 +: 64], e[(fb/64)*64 +: 64], $time);
        end
    endtask

    // Wire-order byte j (0 = first on the wire) is dropped when it falls in the empty tail.
    function automatic logic [DW-1:0] mask_beat(input logic [DW-1:0] d, input bit l, input int em);
        logic [DW-1:0] r;
        r = d;
        if (l)
            for (int j = DWB - em; j < DWB; j++)
                r[DW-1-8*j -: 8] = 8'h00;
        return r;
    endfunction

    // Compare against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (armed) begin
            hold = (expq.size() > 0);
            chk("valid", 64'(phv_valid), 64'(hold));
            chk("ready", 64'(pkt_ready), 64'(!hold));
            if (hold) begin
                chk_phv("phv", phv_out, expq[0].phv);
                chk("len", 64'(phv_len), 64'(expq[0].len));
                chk("trunc", 64'(phv_trunc), 64'(expq[0].trunc));
            end
`ifdef PHV_ASM_STATS_EN
            chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
            chk("trunc_cnt", 64'(trunc_cnt), 64'(m_trunc));
`else
            chk("pkt_cnt", 64'(pkt_cnt), 64'd0);
            chk("trunc_cnt", 64'(trunc_cnt), 64'd0);
`endif
        end
        if (rst) begin
            expq.delete();
            m_acc = '0; m_n = 0; m_drain = 0; m_pkt = 0; m_trunc = 0;
            armed = 1'b1;
        end else if (armed) begin
            if (expq.size() > 0) begin
                if (phv_rdy) begin
                    m_pkt++;
                    if (expq[0].trunc) m_trunc++;
                    void'(expq.pop_front());
                end
            end else if (vld) begin
                if (m_drain) begin
                    if (last) m_drain = 0;
                end else begin
                    m_acc[PW-1-m_n*DW -: DW] = mask_beat(data, last, int'(empty));
                    m_n++;
                    if (last || m_n == BEATS) begin
                        e_item.phv   = m_acc;
                        e_item.len   = last ? m_n*DWB - int'(empty) : PW/8;
                        e_item.trunc = !last;
                        m_drain      = !last;
                        expq.push_back(e_item);
                        m_acc = '0;
                        m_n   = 0;
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit l, input int em);
        bit took;
        int n;
        vld = 1'b1; data = d; last = l; empty = EW'(em);
        n = 0;
        do begin
            @(negedge clk);
            took = pkt_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 100);
        if (!took) begin
            failures++;
            $display("FAIL send_timeout: beat not accepted within %0d cycles", n);
        end
        vld = 1'b0; last = 1'b0; empty = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_valid"}, 64'(phv_valid), 64'd0);
        chk_phv({tag, "_phv"}, phv_out, '0);
        chk({tag, "_len"}, 64'(phv_len), 64'd0);
        chk({tag, "_trunc"}, 64'(phv_trunc), 64'd0);
        chk({tag, "_ready"}, 64'(pkt_ready), 64'd1);
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        chk({tag, "_trunc_cnt"}, 64'(trunc_cnt), 64'd0);
    endtask

    logic [DW-1:0] b1, b2, b3, b4, d1, d2;
    logic [PW-1:0] ex;

    initial begin
        rst = 1'b1; vld = 1'b0; data = '0; last = 1'b0; empty = '0; phv_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero_state("reset");

        // 1-beat packet, 4 empty bytes: top 28 bytes 0xAA, valid the cycle after accept
        send_beat({32{8'hAA}}, 1, 4);
        ex = '0;
        ex[PW-1 -: 224] = {28{8'hAA}};
        chk("p1_valid", 64'(phv_valid), 64'd1);
        chk_phv("p1_phv", phv_out, ex);
        chk("p1_len", 64'(phv_len), 64'd28);
        chk("p1_trunc", 64'(phv_trunc), 64'd0);
        idle(2);

        // exact 4-beat packet
        b1 = {32{8'h11}}; b2 = {32{8'h22}}; b3 = {32{8'h33}}; b4 = {32{8'h44}};
        send_beat(b1, 0, 0);
        send_beat(b2, 0, 0);
        send_beat(b3, 0, 0);
        send_beat(b4, 1, 0);
        chk_phv("p4_phv", phv_out, {b1, b2, b3, b4});
        chk("p4_len", 64'(phv_len), 64'd128);
        chk("p4_trunc", 64'(phv_trunc), 64'd0);

        // 6-beat packet truncated, tail drained, then a clean 2-beat packet
        send_beat({32{8'h61}}, 0, 0);
        send_beat({32{8'h62}}, 0, 0);
        send_beat({32{8'h63}}, 0, 0);
        send_beat({32{8'h64}}, 0, 0);
        chk("p6_len", 64'(phv_len), 64'd128);
        chk("p6_trunc", 64'(phv_trunc), 64'd1);
        send_beat({32{8'h65}}, 0, 0);
        send_beat({32{8'h66}}, 1, 0);
        d1 = {32{8'hD1}}; d2 = {32{8'h5C}};
        send_beat(d1, 0, 0);
        send_beat(d2, 1, 31);
        ex = '0;
        ex[PW-1 -: DW] = d1;
        ex[PW-1-DW -: 8] = 8'h5C;
        chk_phv("p2_phv", phv_out, ex);
        chk("p2_len", 64'(phv_len), 64'd33);
        chk("p2_trunc", 64'(phv_trunc), 64'd0);
        idle(2);

        // downstream stall in HOLD for 10 cycles
        phv_rdy = 1'b0;
        b1 = {32{8'hE7}};
        send_beat(b1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_ready", 64'(pkt_ready), 64'd0);
            chk("stall_valid", 64'(phv_valid), 64'd1);
            chk_phv("stall_phv", phv_out, {b1, 768'd0});
            idle(1);
        end
        phv_rdy = 1'b1;
        idle(1);
        chk("stall_release", 64'(phv_valid), 64'd0);
        idle(1);

        // reset after beat 2 of 3; beat 3 becomes a fresh 1-beat packet at slot 0
        send_beat({32{8'hF1}}, 0, 0);
        send_beat({32{8'hF2}}, 0, 0);
        pulse_reset();
        chk_zero_state("midrst");
        b3 = {32{8'hF3}};
        send_beat(b3, 1, 0);
        chk_phv("midrst_phv", phv_out, {b3, 768'd0});
        chk("midrst_len", 64'(phv_len), 64'd32);
        idle(2);

        // stats: three packets, one truncated
        pulse_reset();
        send_beat({32{8'h71}}, 1, 0);
        for (int k = 0; k < 4; k++)
            send_beat({32{8'h80}} | DW'(k), 0, 0);
        send_beat({32{8'h85}}, 1, 2);
        send_beat({32{8'h91}}, 1, 10);
        idle(3);
`ifdef PHV_ASM_STATS_EN
        chk("stats_pkt", 64'(pkt_cnt), 64'd3);
        chk("stats_trunc", 64'(trunc_cnt), 64'd1);
`else
        chk("stats_pkt", 64'(pkt_cnt), 64'd0);
        chk("stats_trunc", 64'(trunc_cnt), 64'd0);
`endif
        chk("final_idle_ready", 64'(pkt_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
